// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the AES key-expansion unit: accepts a key, steps the unit through its
// rounds and presents round keys to the cipher core in encrypt or decrypt order.
module aes_key_sched_ctrl #(
  parameter int unsigned K = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         ready,
  input  logic         decrypt,
  input  logic [K-1:0] key_in,
  output logic [K-1:0] key_out,
  output logic         exp_reset,
  output logic         exp_done1,
  output logic         exp_done2,
  output logic [3:0]   round,
  output logic         round_valid,
  input  logic         round_ready,
  output logic         last,
  output logic         done
);

  localparam logic [3:0] Nr = (K == 256) ? 4'd14 : (K == 192) ? 4'd12 : 4'd10;

  typedef enum logic [2:0] {StIdle, StLoad, StFwd, StBwd, StDone} state_e;

  state_e         state_q, state_d;
  logic           dir_q, dir_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [K-1:0]   key_q, key_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      cnt_q   <= 4'd0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          key_d   = key_in;
          dir_d   = decrypt;
          cnt_d   = 4'd0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = 4'd0;
        state_d = StFwd;
      end
      StFwd: begin
        // Hidden decrypt rounds advance unconditionally; visible ones wait for the core.
        if (!round_valid) begin
          cnt_d = cnt_q + 4'd1;
        end else if (round_ready) begin
          if (cnt_q == Nr) begin
            if (dir_q) begin
              state_d = StBwd;
              cnt_d   = Nr - 4'd1;
            end else begin
              state_d = StDone;
              cnt_d   = 4'd0;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StBwd: begin
        if (round_ready) begin
          if (cnt_q == 4'd0) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    ready       = (state_q == StIdle);
    exp_reset   = (state_q == StIdle);
    key_out     = key_q;
    round       = cnt_q;
    round_valid = 1'b0;
    last        = 1'b0;
    done        = (state_q == StDone);
    exp_done1   = (state_q == StBwd) || ((state_q == StDone) && dir_q);
    unique case (state_q)
      StFwd: begin
        round_valid = !dir_q || (cnt_q == Nr);
        last        = !dir_q && (cnt_q == Nr);
      end
      StBwd: begin
        round_valid = 1'b1;
        last        = (cnt_q == 4'd0);
      end
      default: begin
        round_valid = 1'b0;
        last        = 1'b0;
      end
    endcase
    // Freezing the unit on a stall keeps the presented round key stable.
    exp_done2 = (state_q == StDone) || (round_valid && !round_ready);
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: table of sequences checked against a queue of expected
// round beats, plus hand-written abort and held-start sequences.
module tb_aes_key_sched_ctrl;

  logic         clk;
  logic         reset;
  logic         start;
  logic         decrypt;
  logic         round_ready;
  logic         sel256;
  logic [255:0] key;
  logic [127:0] key_in128;
  logic [255:0] key_in256;

  logic         ready128, exp_reset128, d1_128, d2_128, rv128, last128, done128;
  logic [3:0]   round128;
  logic [127:0] key_out128;
  logic         ready256, exp_reset256, d1_256, d2_256, rv256, last256, done256;
  logic [3:0]   round256;
  logic [255:0] key_out256;

  logic         m_ready, m_exp_reset, m_d1, m_d2, m_rv, m_last, m_done;
  logic [3:0]   m_round;
  logic [255:0] m_key;

  int checks;
  int errors;

  typedef struct {
    bit use256;
    bit dec;
    int stall_at;
    int stall_len;
    int exp_done;
  } vec_t;

  typedef struct {
    int rnd;
    bit lst;
  } beat_t;

  vec_t  tbl[6];
  beat_t q[$];

  aes_key_sched_ctrl #(.K(128)) dut128 (
    .clk(clk), .reset(reset), .start(start && !sel256), .ready(ready128),
    .decrypt(decrypt), .key_in(key_in128), .key_out(key_out128), .exp_reset(exp_reset128),
    .exp_done1(d1_128), .exp_done2(d2_128), .round(round128), .round_valid(rv128),
    .round_ready(round_ready), .last(last128), .done(done128)
  );

  aes_key_sched_ctrl #(.K(256)) dut256 (
    .clk(clk), .reset(reset), .start(start && sel256), .ready(ready256),
    .decrypt(decrypt), .key_in(key_in256), .key_out(key_out256), .exp_reset(exp_reset256),
    .exp_done1(d1_256), .exp_done2(d2_256), .round(round256), .round_valid(rv256),
    .round_ready(round_ready), .last(last256), .done(done256)
  );

  assign m_ready     = sel256 ? ready256     : ready128;
  assign m_exp_reset = sel256 ? exp_reset256 : exp_reset128;
  assign m_d1        = sel256 ? d1_256       : d1_128;
  assign m_d2        = sel256 ? d2_256       : d2_128;
  assign m_rv        = sel256 ? rv256        : rv128;
  assign m_last      = sel256 ? last256      : last128;
  assign m_done      = sel256 ? done256      : done128;
  assign m_round     = sel256 ? round256     : round128;
  assign m_key       = sel256 ? key_out256   : {128'd0, key_out128};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, m_ready, 1);
    chk({tag, "_exp_reset"}, m_exp_reset, 1);
    chk({tag, "_rv"}, m_rv, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_round"}, m_round, 0);
    chk({tag, "_key_out"}, m_key, 0);
    chk({tag, "_d1"}, m_d1, 0);
    chk({tag, "_d2"}, m_d2, 0);
  endtask

  task automatic run_seq(input vec_t v, input bit hold, input int abort_at);
    int    nr;
    int    cyc;
    int    stalls;
    int    done_cyc;
    bit    fin;
    bit    aborted;
    beat_t e;
    nr       = v.use256 ? 14 : 10;
    sel256   = v.use256;
    stalls   = 0;
    done_cyc = -1;
    fin      = 0;
    aborted  = 0;
    q.delete();
    for (int i = 0; i <= nr; i++) begin
      e.rnd = v.dec ? nr - i : i;
      e.lst = (i == nr);
      q.push_back(e);
    end
    if (v.use256) key = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
    else key = {128'd0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c};
    @(negedge clk);
    chk("idle_ready", m_ready, 1);
    chk("idle_exp_reset", m_exp_reset, 1);
    decrypt   = v.dec;
    key_in128 = key[127:0];
    key_in256 = key;
    start     = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    decrypt   = ~v.dec;
    key_in128 = ~key[127:0];
    key_in256 = ~key;
    cyc = 0;
    while (!fin && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (m_rv && m_round == 4'(v.stall_at) && stalls < v.stall_len) begin
        round_ready = 1'b0;
        stalls++;
      end else begin
        round_ready = 1'b1;
      end
      #1;
      if (cyc == 1) begin
        chk("load_ready", m_ready, 0);
        chk("load_exp_reset", m_exp_reset, 0);
        chk("load_key_out", m_key, key);
      end
      if (abort_at >= 0 && m_rv && m_d1 && m_round == 4'(abort_at)) begin
        reset = 1'b0;
        start = 1'b0;
        #1;
        chk_reset_outs("abort");
        #1;
        reset   = 1'b1;
        aborted = 1;
        fin     = 1;
      end else begin
        chk("exp_done2", m_d2, (m_rv && !round_ready) || m_done);
        if (m_rv && round_ready) begin
          if (q.size() == 0) begin
            chk("extra_beat", 1, 0);
          end else begin
            e = q.pop_front();
            chk("round", m_round, e.rnd);
            chk("last", m_last, e.lst);
          end
        end else if (!m_rv) begin
          chk("last_no_valid", m_last, 0);
        end
        if (v.dec && v.stall_len == 0 && cyc >= 2 && cyc <= nr + 1) chk("hidden_rv", m_rv, 0);
        if (v.dec && v.stall_len == 0 && cyc == nr + 3) chk("bwd_done1", m_d1, 1);
        if (m_done) begin
          done_cyc = cyc;
          fin      = 1;
          chk("done_ready", m_ready, 0);
          chk("done_done1", m_d1, v.dec);
        end
      end
    end
    round_ready = 1'b1;
    if (aborted) begin
      q.delete();
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("post_abort_done", m_done, 0);
        chk("post_abort_ready", m_ready, 1);
      end
    end else begin
      chk("done_cycle", done_cyc, v.exp_done);
      chk("queue_empty", q.size(), 0);
      @(negedge clk);
      chk("ready_after_done", m_ready, 1);
      if (hold) begin
        @(negedge clk);
        chk("reaccept_load", m_exp_reset, 0);
        start = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
      end
    end
  endtask

  initial begin
    vec_t v;
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    start       = 1'b0;
    decrypt     = 1'b0;
    round_ready = 1'b1;
    sel256      = 1'b0;
    key         = '0;
    key_in128   = '1;
    key_in256   = '1;

    //            use256 dec stall_at stall_len exp_done
    tbl[0] = '{0, 0, -1, 0, 13};
    tbl[1] = '{0, 1, -1, 0, 23};
    tbl[2] = '{0, 0,  4, 3, 16};
    tbl[3] = '{1, 1, -1, 0, 31};
    tbl[4] = '{1, 0, -1, 0, 17};
    tbl[5] = '{0, 1,  2, 2, 25};

    repeat (3) @(negedge clk);
    start = 1'b1;
    chk_reset_outs("rst128");
    sel256 = 1'b1;
    #1;
    chk_reset_outs("rst256");
    sel256 = 1'b0;
    start  = 1'b0;
    reset  = 1'b1;

    for (int i = 0; i < 6; i++) run_seq(tbl[i], 1'b0, -1);

    // Abort a decrypt mid-BWD, then confirm a clean sequence follows.
    run_seq(tbl[1], 1'b0, 6);
    run_seq(tbl[0], 1'b0, -1);

    // Start held high: second accept only once IDLE returns.
    run_seq(tbl[0], 1'b1, -1);
    run_seq(tbl[3], 1'b0, -1);

    v = '{0, 1, 9, 1, 24};
    run_seq(v, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
